// File: rtl/im_boot_loader.sv
// -----------------------------------------------------------------------------
// im_boot_loader
//
// Boot sequencer for the CPU + instruction-memory subsystem. A program arrives
// as a byte stream over a valid/ready handshake. The stream starts with a
// length byte N, where N=0 means 2**ADDR_W words. N words follow, each sent as
// a hi byte and then a lo byte. The stream ends with an XOR checksum byte.
//
// Each word is written into the instruction memory through its external write
// port. The CPU is held in reset for the whole load. If the checksum matches,
// the loader releases the CPU and gives it a one-cycle start pulse. If it does
// not match, the loader parks in an error state with the CPU still in reset.
//
// Ports
//   clock        in   1         system clock, rising edge
//   reset        in   1         synchronous, active-high
//   load_req     in   1         request a new program load (ignored while busy)
//   rx_valid     in   1         rx_data holds a byte
//   rx_data      in   8         incoming byte
//   rx_ready     out  1         loader accepts a byte this cycle
//   im_we        out  1         IM write enable, one cycle per word
//   im_addr      out  ADDR_W    IM word address (holds last written address)
//   im_data      out  DATA_W    IM write data {hi,lo} (holds last written word)
//   cpu_reset    out  1         hold CPU in reset
//   cpu_start    out  1         one-cycle start pulse to the CPU
//   busy         out  1         load in progress
//   error        out  1         last load failed its checksum
//   words_loaded out  ADDR_W+1  words written in the current/last load
// -----------------------------------------------------------------------------
module im_boot_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_data,
  output logic              cpu_reset,
  output logic              cpu_start,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_CHK,
    ST_START,
    ST_RUN,
    ST_ERR
  } state_t;

  state_t state_q, state_d;

  logic [7:0]        len_q;
  logic [7:0]        hi_q;
  logic [7:0]        chk_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [DATA_W-1:0] im_data_q;
  logic [ADDR_W:0]   words_q;
  logic              error_q;

  logic [ADDR_W:0]   word_target;
  logic [ADDR_W:0]   words_next;
  logic              last_word;

  // A length byte of zero stands for a full memory (2**ADDR_W words).
  // The target is therefore one bit wider than the address.
  always_comb begin
    if (len_q == 8'd0) begin
      word_target = {1'b1, {ADDR_W{1'b0}}};
    end else begin
      word_target = (ADDR_W + 1)'(len_q);
    end
  end

  assign words_next = words_q + 1'b1;
  assign last_word  = (words_next == word_target);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and control outputs. rx_ready is asserted only in
  // byte-consuming states. So wherever a byte is taken, accept is simply
  // rx_valid. A sender that holds rx_valid through a WRITE cycle is not
  // consumed.
  always_comb begin
    state_d   = state_q;
    rx_ready  = 1'b0;
    im_we     = 1'b0;
    cpu_reset = 1'b1;
    cpu_start = 1'b0;
    busy      = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (load_req) state_d = ST_LEN;
      end
      ST_RUN: begin
        cpu_reset = 1'b0;
        if (load_req) state_d = ST_LEN;
      end
      ST_LEN: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_d = ST_HI;
      end
      ST_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_d = ST_LO;
      end
      ST_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        im_we = 1'b1;
        busy  = 1'b1;
        if (last_word) begin
          state_d = ST_CHK;
        end else begin
          state_d = ST_HI;
        end
      end
      ST_CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            state_d = ST_START;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_START: begin
        cpu_reset = 1'b0;
        cpu_start = 1'b1;
        state_d   = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath.
  // The write pointer is kept separate from the im_addr register. This lets
  // im_addr keep showing the last written address after WRITE, while the
  // pointer has already moved on to the next slot.
  // im_addr and im_data are loaded when the lo byte arrives, so both are
  // valid during the WRITE cycle.
  // IM contents are outside this block, so a reset only clears the loader.
  always_ff @(posedge clock) begin
    if (reset) begin
      len_q     <= '0;
      hi_q      <= '0;
      chk_q     <= '0;
      wr_ptr_q  <= '0;
      im_addr_q <= '0;
      im_data_q <= '0;
      words_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (load_req) begin
            error_q   <= 1'b0;
            words_q   <= '0;
            im_addr_q <= '0;
            wr_ptr_q  <= '0;
            chk_q     <= '0;
          end
        end
        ST_LEN: begin
          if (rx_valid) begin
            len_q <= rx_data;
            chk_q <= rx_data;
          end
        end
        ST_HI: begin
          if (rx_valid) begin
            hi_q  <= rx_data;
            chk_q <= chk_q ^ rx_data;
          end
        end
        ST_LO: begin
          if (rx_valid) begin
            im_data_q <= {hi_q, rx_data};
            im_addr_q <= wr_ptr_q;
            chk_q     <= chk_q ^ rx_data;
          end
        end
        ST_WRITE: begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          words_q  <= words_next;
        end
        ST_CHK: begin
          if (rx_valid && (rx_data != chk_q)) error_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign im_addr      = im_addr_q;
  assign im_data      = im_data_q;
  assign words_loaded = words_q;
  assign error        = error_q;

endmodule

// File: tb/tb_im_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_im_boot_loader
//
// Directed bench for im_boot_loader. Bytes are presented on rx_valid/rx_data
// and the loader's outputs are compared against hand-computed values.
// A negedge monitor logs every IM write and counts cpu_start pulses, so whole
// loads can be compared afterwards.
// -----------------------------------------------------------------------------
module tb_im_boot_loader;

  logic        clock;
  logic        reset;
  logic        load_req;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [15:0] im_data;
  logic        cpu_reset;
  logic        cpu_start;
  logic        busy;
  logic        error;
  logic [8:0]  words_loaded;

  int checks = 0;
  int errors = 0;
  int start_count = 0;

  logic [7:0]  wr_addr_log [$];
  logic [15:0] wr_data_log [$];
  logic [7:0]  bytes_q [$];

  im_boot_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .load_req     (load_req),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_data      (im_data),
    .cpu_reset    (cpu_reset),
    .cpu_start    (cpu_start),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Log writes and start pulses half a cycle after each active edge.
  always @(negedge clock) begin
    if (im_we === 1'b1) begin
      wr_addr_log.push_back(im_addr);
      wr_data_log.push_back(im_data);
    end
    if (cpu_start === 1'b1) start_count++;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one byte and return #1 after the edge that accepted it.
  // With hold=1, rx_valid stays high, as if the sender always has a byte.
  task automatic apply_stimulus(input logic [7:0] b, input bit hold);
    int cnt;
    cnt      = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && cnt < 100) begin
      @(negedge clock);
      cnt++;
    end
    if (cnt >= 100) check_output("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(posedge clock);
    #1;
    if (!hold) rx_valid = 1'b0;
  endtask

  task automatic send_queue(input bit hold);
    foreach (bytes_q[i]) apply_stimulus(bytes_q[i], hold);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_load_req();
    @(negedge clock);
    load_req = 1'b1;
    @(posedge clock);
    #1;
    load_req = 1'b0;
  endtask

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int base_starts;
    int bad;
    logic [7:0] x;

    reset    = 1'b1;
    load_req = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle_cycles(3);

    // ---------------- reset state ----------------
    $display("[TB] reset state");
    check_output("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check_output("rst_im_we", {31'd0, im_we}, 32'd0);
    check_output("rst_im_addr", {24'd0, im_addr}, 32'd0);
    check_output("rst_im_data", {16'd0, im_data}, 32'd0);
    check_output("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check_output("rst_cpu_start", {31'd0, cpu_start}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_error", {31'd0, error}, 32'd0);
    check_output("rst_words", {23'd0, words_loaded}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    idle_cycles(2);

    // ---------------- test 1: basic two-word boot ----------------
    $display("[TB] test 1: basic load");
    clear_logs();
    base_starts = start_count;
    pulse_load_req();
    check_output("t1_busy", {31'd0, busy}, 32'd1);
    check_output("t1_ready_len", {31'd0, rx_ready}, 32'd1);
    apply_stimulus(8'h02, 0);
    apply_stimulus(8'h12, 0);
    apply_stimulus(8'h34, 0);
    check_output("t1_we_w0", {31'd0, im_we}, 32'd1);
    check_output("t1_addr_w0", {24'd0, im_addr}, 32'h00);
    check_output("t1_data_w0", {16'd0, im_data}, 32'h1234);
    apply_stimulus(8'hAB, 0);
    apply_stimulus(8'hCD, 0);
    check_output("t1_we_w1", {31'd0, im_we}, 32'd1);
    check_output("t1_addr_w1", {24'd0, im_addr}, 32'h01);
    check_output("t1_data_w1", {16'd0, im_data}, 32'hABCD);
    apply_stimulus(8'h42, 0);
    check_output("t1_cpu_start", {31'd0, cpu_start}, 32'd1);
    check_output("t1_cpu_reset_start", {31'd0, cpu_reset}, 32'd0);
    idle_cycles(1);
    check_output("t1_start_pulse_end", {31'd0, cpu_start}, 32'd0);
    check_output("t1_cpu_reset_run", {31'd0, cpu_reset}, 32'd0);
    check_output("t1_words", {23'd0, words_loaded}, 32'd2);
    check_output("t1_error", {31'd0, error}, 32'd0);
    check_output("t1_busy_run", {31'd0, busy}, 32'd0);
    check_output("t1_addr_hold", {24'd0, im_addr}, 32'h01);
    idle_cycles(2);
    check_output("t1_start_count", start_count - base_starts, 32'd1);
    check_output("t1_write_count", wr_addr_log.size(), 32'd2);

    // ---------------- test 6 + 2: reload from RUN, bad checksum ----------
    $display("[TB] test 6/2: reload from RUN with bad checksum");
    clear_logs();
    base_starts = start_count;
    pulse_load_req();
    check_output("t6_cpu_reset_reassert", {31'd0, cpu_reset}, 32'd1);
    check_output("t6_words_cleared", {23'd0, words_loaded}, 32'd0);
    bytes_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    send_queue(0);
    check_output("t2_error", {31'd0, error}, 32'd1);
    check_output("t2_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check_output("t2_busy", {31'd0, busy}, 32'd0);
    check_output("t2_no_ready_err", {31'd0, rx_ready}, 32'd0);
    idle_cycles(3);
    check_output("t2_no_start", start_count - base_starts, 32'd0);
    check_output("t2_error_sticky", {31'd0, error}, 32'd1);
    pulse_load_req();
    check_output("t2_error_cleared", {31'd0, error}, 32'd0);
    bytes_q = '{8'h01, 8'h5A, 8'hC3, 8'h00};
    bytes_q[3] = 8'h01 ^ 8'h5A ^ 8'hC3;
    send_queue(0);
    check_output("t2_reboot_start", {31'd0, cpu_start}, 32'd1);
    idle_cycles(1);
    check_output("t2_reboot_words", {23'd0, words_loaded}, 32'd1);
    check_output("t2_reboot_addr", {24'd0, wr_addr_log[wr_addr_log.size()-1]}, 32'h00);
    check_output("t2_reboot_data", {16'd0, wr_data_log[wr_data_log.size()-1]}, 32'h5AC3);

    // ---------------- test 3: full memory via LEN=0 ----------------
    $display("[TB] test 3: 256-word load");
    clear_logs();
    base_starts = start_count;
    pulse_load_req();
    bytes_q.delete();
    bytes_q.push_back(8'h00);
    x = 8'h00;
    for (int i = 0; i < 256; i++) begin
      bytes_q.push_back(i[7:0]);
      bytes_q.push_back(~i[7:0]);
      x = x ^ i[7:0] ^ ~i[7:0];
    end
    bytes_q.push_back(x);
    send_queue(0);
    check_output("t3_start", {31'd0, cpu_start}, 32'd1);
    idle_cycles(2);
    check_output("t3_write_count", wr_addr_log.size(), 32'd256);
    check_output("t3_words", {23'd0, words_loaded}, 32'd256);
    check_output("t3_last_addr", {24'd0, wr_addr_log[255]}, 32'hFF);
    check_output("t3_last_data", {16'd0, wr_data_log[255]}, 32'hFF00);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (wr_addr_log[i] !== i[7:0] || wr_data_log[i] !== {i[7:0], ~i[7:0]}) bad++;
    end
    check_output("t3_all_words", bad, 32'd0);
    check_output("t3_start_count", start_count - base_starts, 32'd1);

    // ---------------- test 4: rx_valid held high, load_req during load ----
    $display("[TB] test 4: continuous valid, load_req ignored while busy");
    clear_logs();
    base_starts = start_count;
    pulse_load_req();
    apply_stimulus(8'h03, 1);
    apply_stimulus(8'h11, 1);
    load_req = 1'b1;
    apply_stimulus(8'h22, 1);
    check_output("t4_ready_low_write", {31'd0, rx_ready}, 32'd0);
    check_output("t4_we_write", {31'd0, im_we}, 32'd1);
    apply_stimulus(8'h33, 1);
    load_req = 1'b0;
    apply_stimulus(8'h44, 1);
    apply_stimulus(8'h55, 1);
    apply_stimulus(8'h66, 1);
    check_output("t4_ready_low_write3", {31'd0, rx_ready}, 32'd0);
    apply_stimulus(8'h74, 1);
    rx_valid = 1'b0;
    check_output("t4_start", {31'd0, cpu_start}, 32'd1);
    idle_cycles(2);
    check_output("t4_write_count", wr_addr_log.size(), 32'd3);
    check_output("t4_words", {23'd0, words_loaded}, 32'd3);
    check_output("t4_w0", {8'd0, wr_addr_log[0], wr_data_log[0]}, 32'h00_1122);
    check_output("t4_w1", {8'd0, wr_addr_log[1], wr_data_log[1]}, 32'h01_3344);
    check_output("t4_w2", {8'd0, wr_addr_log[2], wr_data_log[2]}, 32'h02_5566);
    check_output("t4_error", {31'd0, error}, 32'd0);

    // ---------------- test 5: reset mid-load ----------------
    $display("[TB] test 5: reset mid-load");
    clear_logs();
    pulse_load_req();
    bytes_q = '{8'h04, 8'h01, 8'h02, 8'h03};
    send_queue(0);
    check_output("t5_words_before", {23'd0, words_loaded}, 32'd1);
    check_output("t5_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    check_output("t5_busy", {31'd0, busy}, 32'd0);
    check_output("t5_rx_ready", {31'd0, rx_ready}, 32'd0);
    check_output("t5_im_we", {31'd0, im_we}, 32'd0);
    check_output("t5_im_addr", {24'd0, im_addr}, 32'd0);
    check_output("t5_im_data", {16'd0, im_data}, 32'd0);
    check_output("t5_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check_output("t5_cpu_start", {31'd0, cpu_start}, 32'd0);
    check_output("t5_words", {23'd0, words_loaded}, 32'd0);
    check_output("t5_error", {31'd0, error}, 32'd0);
    idle_cycles(2);
    clear_logs();
    base_starts = start_count;
    pulse_load_req();
    bytes_q = '{8'h01, 8'hBE, 8'hEF, 8'h50};
    send_queue(0);
    check_output("t5_start", {31'd0, cpu_start}, 32'd1);
    idle_cycles(2);
    check_output("t5_write_count", wr_addr_log.size(), 32'd1);
    check_output("t5_fresh_w0", {8'd0, wr_addr_log[0], wr_data_log[0]}, 32'h00_BEEF);
    check_output("t5_start_count", start_count - base_starts, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
